// File: rtl/tristate_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_bus_arbiter_if
//  Description : Request/grant bundle between the requesting agents and the
//                tristate bus arbiter. The master modport is the arbiter side,
//                the slave modport is the agent / driver-row side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tristate_bus_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int c_owner_w = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     grant;
  logic [N_REQ-1:0]     drv_en_n;
  logic [c_owner_w-1:0] owner;
  logic                 bus_idle;
  logic                 preempt;

  modport master (
    input  req,
    output grant,
    output drv_en_n,
    output owner,
    output bus_idle,
    output preempt
  );

  modport slave (
    output req,
    input  grant,
    input  drv_en_n,
    input  owner,
    input  bus_idle,
    input  preempt
  );
endinterface
`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_bus_arbiter
//  Description : Round-robin sequencer for a shared tristate bus. Drives the
//                active-low notif0 enables so at most one driver leaves Z, and
//                inserts TURNAROUND all-Z cycles between successive owners.
//                Optional hold-limit preemption is compiled in with the macro
//                TBA_PREEMPT_EN (default build: no preemption, preempt = 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tristate_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int HOLD_MAX   = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  tristate_bus_arbiter_if.master bus
);

  localparam int                   c_owner_w   = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]           c_turn_last = 4'(TURNAROUND - 1);
  localparam logic [N_REQ-1:0]     c_one       = N_REQ'(1);
  localparam logic [c_owner_w-1:0] c_last_rst  = c_owner_w'(N_REQ - 1);
`ifdef TBA_PREEMPT_EN
  localparam logic [7:0]           c_hold_last = 8'(HOLD_MAX - 1);
`endif

  // Elaboration-time guard on the legal parameter ranges
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("tristate_bus_arbiter: N_REQ out of range 2..16");
  end
  if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
    $error("tristate_bus_arbiter: TURNAROUND out of range 1..15");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("tristate_bus_arbiter: HOLD_MAX out of range 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t               r_state;
  logic [N_REQ-1:0]     r_grant;
  logic [c_owner_w-1:0] r_owner;
  logic [c_owner_w-1:0] r_last;
  logic [3:0]           r_turn_cnt;
  logic [7:0]           r_hold_cnt;
`ifdef TBA_PREEMPT_EN
  logic                 r_preempt;
  logic                 w_hold_hit;
`endif

  logic                 w_any_req;
  logic                 w_own_req;
  logic [c_owner_w-1:0] w_winner;
  logic [c_owner_w-1:0] w_sel;
  int                   w_idx;

  assign w_any_req = |bus.req;
  // The grant vector is one-hot, so masking req with it isolates req[owner]
  assign w_own_req = |(bus.req & r_grant);
`ifdef TBA_PREEMPT_EN
  assign w_hold_hit = (r_hold_cnt == c_hold_last);
`endif

  // Round-robin pick: scan downward so the index nearest last+1 wins
  always_comb begin
    w_winner = r_last;
    w_idx    = 0;
    w_sel    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = (int'(r_last) + i) % N_REQ;
      w_sel = c_owner_w'(w_idx);
      if (bus.req[w_sel]) w_winner = w_sel;
    end
  end

  // Bus ownership FSM with registered grant/owner/preempt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_last     <= c_last_rst;
      r_turn_cnt <= '0;
      r_hold_cnt <= '0;
`ifdef TBA_PREEMPT_EN
      r_preempt  <= 1'b0;
`endif
    end else begin
`ifdef TBA_PREEMPT_EN
      r_preempt <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state    <= ST_OWN;
            r_grant    <= c_one << w_winner;
            r_owner    <= w_winner;
            r_last     <= w_winner;
            r_hold_cnt <= '0;
          end
        end
        ST_OWN: begin
          if (!w_own_req) begin
            r_state    <= ST_TURN;
            r_grant    <= '0;
            r_owner    <= '0;
            r_turn_cnt <= '0;
`ifdef TBA_PREEMPT_EN
          // A release on the hold-limit edge wins over preemption
          end else if (w_hold_hit) begin
            r_state    <= ST_TURN;
            r_grant    <= '0;
            r_owner    <= '0;
            r_turn_cnt <= '0;
            r_preempt  <= 1'b1;
`endif
          end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        ST_TURN: begin
          // Only the final turnaround cycle's request sample is arbitrated
          if (r_turn_cnt == c_turn_last) begin
            if (w_any_req) begin
              r_state    <= ST_OWN;
              r_grant    <= c_one << w_winner;
              r_owner    <= w_winner;
              r_last     <= w_winner;
              r_hold_cnt <= '0;
            end else begin
              r_state    <= ST_IDLE;
            end
          end else begin
            r_turn_cnt <= r_turn_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_owner <= '0;
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.drv_en_n = ~r_grant;
  assign bus.owner    = r_owner;
  assign bus.bus_idle = (r_state != ST_OWN);
`ifdef TBA_PREEMPT_EN
  assign bus.preempt  = r_preempt;
`else
  assign bus.preempt  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tristate_bus_arbiter
//  Description : Scoreboard bench for tristate_bus_arbiter. Directed stimulus
//                pushes expected grant transitions (cycle, grant, owner) and
//                preempt pulses into queues; per-DUT monitors pop and compare
//                whenever the grant vector changes or preempt pulses, and check
//                the bus invariants every cycle. dut_a: TURNAROUND=1,
//                HOLD_MAX=8. dut_b: TURNAROUND=3, HOLD_MAX=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tristate_bus_arbiter;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [1:0] own;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  ev_t q_a[$];
  ev_t q_b[$];
  int  q_pa[$];
  int  q_pb[$];

  tristate_bus_arbiter_if #(.N_REQ(4)) bus_a ();
  tristate_bus_arbiter_if #(.N_REQ(4)) bus_b ();

  tristate_bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .HOLD_MAX(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  tristate_bus_arbiter #(.N_REQ(4), .TURNAROUND(3), .HOLD_MAX(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ev_a(input int c, input logic [3:0] g, input logic [1:0] o);
    q_a.push_back('{cyc: c, g: g, own: o});
  endtask

  task automatic ev_b(input int c, input logic [3:0] g, input logic [1:0] o);
    q_b.push_back('{cyc: c, g: g, own: o});
  endtask

  // ---------------- monitor for dut_a ----------------
  logic [3:0] prev_a = 4'b0000;
  int         zrun_a = 0;
  bit         seen_a = 1'b0;

  always @(negedge clk) begin
    ev_t        e;
    logic [3:0] dn;
    int         p;
    dn = ~bus_a.grant;
    chk("a_onehot0", 32'($onehot0(bus_a.grant)), 32'd1);
    chk("a_drv_en_n", 32'(bus_a.drv_en_n), 32'(dn));
    if (bus_a.preempt) begin
      if (q_pa.size() == 0) chk("a_preempt_unexpected", 32'(bus_a.preempt), 32'd0);
      else begin
        p = q_pa.pop_front();
        chk("a_preempt_cycle", 32'(cyc), 32'(p));
      end
    end
    if (bus_a.grant !== prev_a) begin
      if (q_a.size() == 0) chk("a_unexpected_grant", 32'(bus_a.grant), 32'(prev_a));
      else begin
        e = q_a.pop_front();
        chk("a_event_cycle", 32'(cyc), 32'(e.cyc));
        chk("a_grant", 32'(bus_a.grant), 32'(e.g));
        chk("a_owner", 32'(bus_a.owner), 32'(e.own));
        chk("a_bus_idle", 32'(bus_a.bus_idle), 32'(e.g == 4'b0000));
      end
      if (bus_a.grant != 4'b0000) begin
        if (prev_a != 4'b0000) chk("a_direct_handoff", 32'(prev_a), 32'd0);
        else if (seen_a) chk("a_turn_gap_ge_1", 32'(zrun_a >= 1), 32'd1);
        seen_a = 1'b1;
      end
    end
    if (bus_a.grant == 4'b0000) zrun_a++;
    else zrun_a = 0;
    prev_a = bus_a.grant;
  end

  // ---------------- monitor for dut_b ----------------
  logic [3:0] prev_b = 4'b0000;
  int         zrun_b = 0;
  bit         seen_b = 1'b0;

  always @(negedge clk) begin
    ev_t        e;
    logic [3:0] dn;
    int         p;
    dn = ~bus_b.grant;
    chk("b_onehot0", 32'($onehot0(bus_b.grant)), 32'd1);
    chk("b_drv_en_n", 32'(bus_b.drv_en_n), 32'(dn));
    if (bus_b.preempt) begin
      if (q_pb.size() == 0) chk("b_preempt_unexpected", 32'(bus_b.preempt), 32'd0);
      else begin
        p = q_pb.pop_front();
        chk("b_preempt_cycle", 32'(cyc), 32'(p));
      end
    end
    if (bus_b.grant !== prev_b) begin
      if (q_b.size() == 0) chk("b_unexpected_grant", 32'(bus_b.grant), 32'(prev_b));
      else begin
        e = q_b.pop_front();
        chk("b_event_cycle", 32'(cyc), 32'(e.cyc));
        chk("b_grant", 32'(bus_b.grant), 32'(e.g));
        chk("b_owner", 32'(bus_b.owner), 32'(e.own));
        chk("b_bus_idle", 32'(bus_b.bus_idle), 32'(e.g == 4'b0000));
      end
      if (bus_b.grant != 4'b0000) begin
        if (prev_b != 4'b0000) chk("b_direct_handoff", 32'(prev_b), 32'd0);
        else if (seen_b) chk("b_turn_gap_ge_3", 32'(zrun_b >= 3), 32'd1);
        seen_b = 1'b1;
      end
    end
    if (bus_b.grant == 4'b0000) zrun_b++;
    else zrun_b = 0;
    prev_b = bus_b.grant;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         c0;
    logic [1:0] o;
    logic [3:0] oh;

    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    chk("rst_a_grant",    32'(bus_a.grant),    32'h0);
    chk("rst_a_drv_en_n", 32'(bus_a.drv_en_n), 32'hF);
    chk("rst_a_owner",    32'(bus_a.owner),    32'h0);
    chk("rst_a_bus_idle", 32'(bus_a.bus_idle), 32'h1);
    chk("rst_a_preempt",  32'(bus_a.preempt),  32'h0);
    chk("rst_b_grant",    32'(bus_b.grant),    32'h0);
    chk("rst_b_bus_idle", 32'(bus_b.bus_idle), 32'h1);

    // Round-robin from reset: owners 0,1,2,3,0, each holding 2 cycles
    bus_a.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      o  = 2'(k % 4);
      oh = 4'b0001 << o;
      ev_a(cyc + 1, oh, o);
      ev_a(cyc + 3, 4'b0000, 2'd0);
      tick(2);
      bus_a.req[o] = 1'b0;
      tick(1);
      if (k < 4) bus_a.req[o] = 1'b1;
      else bus_a.req = 4'b0000;
    end
    tick(3);

    // Single request: grant one cycle later, release one cycle after drop
    c0 = cyc;
    bus_a.req = 4'b0010;
    ev_a(c0 + 1, 4'b0010, 2'd1);
    tick(5);
    bus_a.req = 4'b0000;
    ev_a(c0 + 6, 4'b0000, 2'd0);
    tick(3);
    chk("single_bus_idle", 32'(bus_a.bus_idle), 32'h1);

    // Owner 2 drops on the same edge req[3] rises
    c0 = cyc;
    bus_a.req = 4'b0100;
    ev_a(c0 + 1, 4'b0100, 2'd2);
    tick(2);
    bus_a.req = 4'b1000;
    ev_a(c0 + 3, 4'b0000, 2'd0);
    ev_a(c0 + 4, 4'b1000, 2'd3);
    tick(3);
    bus_a.req = 4'b0000;
    ev_a(c0 + 6, 4'b0000, 2'd0);
    tick(3);

    // Asynchronous reset in the middle of an ownership
    c0 = cyc;
    bus_a.req = 4'b0100;
    ev_a(c0 + 1, 4'b0100, 2'd2);
    tick(2);
    chk("pre_reset_grant", 32'(bus_a.grant), 32'h4);
    #2;
    ev_a(c0 + 2, 4'b0000, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant",    32'(bus_a.grant),    32'h0);
    chk("async_rst_drv_en_n", 32'(bus_a.drv_en_n), 32'hF);
    bus_a.req = 4'b0000;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_bus_idle", 32'(bus_a.bus_idle), 32'h1);
    chk("post_rst_grant",    32'(bus_a.grant),    32'h0);

    // TURNAROUND=3: owner 0 releases with req[2] pending; TURN glitch ignored
    c0 = cyc;
    bus_b.req = 4'b0001;
    ev_b(c0 + 1, 4'b0001, 2'd0);
    tick(1);
    bus_b.req = 4'b0101;
    tick(1);
    bus_b.req = 4'b0100;
    ev_b(c0 + 3, 4'b0000, 2'd0);
    ev_b(c0 + 6, 4'b0100, 2'd2);
    tick(1);
    bus_b.req = 4'b0110;
    tick(1);
    bus_b.req = 4'b0100;
    tick(3);
    bus_b.req = 4'b0000;
    ev_b(c0 + 8, 4'b0000, 2'd0);
    tick(5);

    // Hold limit with req = 0011 held constantly
    c0 = cyc;
    bus_b.req = 4'b0011;
    ev_b(c0 + 1, 4'b0001, 2'd0);
`ifdef TBA_PREEMPT_EN
    ev_b(c0 + 5, 4'b0000, 2'd0);
    q_pb.push_back(c0 + 5);
    ev_b(c0 + 8, 4'b0010, 2'd1);
    tick(9);
    bus_b.req = 4'b0000;
    ev_b(c0 + 10, 4'b0000, 2'd0);
    tick(6);
`else
    tick(100);
    chk("no_preempt_grant_held", 32'(bus_b.grant), 32'h1);
    bus_b.req = 4'b0000;
    ev_b(c0 + 101, 4'b0000, 2'd0);
    tick(6);
`endif

    tick(2);
    chk("leftover_events_a",  32'(q_a.size()),  32'd0);
    chk("leftover_events_b",  32'(q_b.size()),  32'd0);
    chk("leftover_preempt_a", 32'(q_pa.size()), 32'd0);
    chk("leftover_preempt_b", 32'(q_pb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Sequencer for a shared tristate bus built from `notif0`/`bufif` driver cells. Up to `N_REQ` requesters contend for the bus. The block grants it round-robin and drives the active-low per-driver enables so that at most one driver is ever out of Z. It inserts a guaranteed all-Z turnaround gap between owners and can optionally preempt an owner after a hold limit. It sits between the requesting agents and the gate-level driver row.

## Interface
- `N_REQ`, default 4: number of requesters/drivers; legal range 2..16.
- `TURNAROUND`, default 1: all-Z cycles between successive owners; legal range 1..15.
- `HOLD_MAX`, default 8: maximum consecutive OWN cycles per grant when preemption is compiled in; legal range 1..255.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input `N_REQ`: level request; bit i is held high while agent i wants the bus.
- `grant` output `N_REQ`: one-hot or zero; registered.
- `drv_en_n` output `N_REQ`: active-low driver enables wired to the `notif0` enables; always equal to `~grant`.
- `owner` output `max(1,$clog2(N_REQ))`: index of the current owner; 0 when the bus is idle.
- `bus_idle` output 1: high in IDLE and TURN, meaning no driver is enabled.
- `preempt` output 1: one-cycle pulse on forced release; only when `TBA_PREEMPT_EN` is compiled in, otherwise tied 0.

## Operation
- **States:**
  - IDLE: no owner.
  - OWN: exactly one grant bit set.
  - TURN: turnaround in progress.
- **IDLE:**
  - If `req`≠0, pick the winner round-robin and go to OWN at the next edge.
  - Otherwise stay in IDLE.
- **Round-robin:**
  - Search starts at index `last+1` (mod `N_REQ`).
  - `last` is the most recent owner and resets to `N_REQ-1`, so index 0 wins first.
- **OWN:**
  - The grant holds while `req[owner]`=1.
  - When `req[owner]`=0 is sampled, go to TURN at the next edge.
  - Requests from other agents do not disturb the current owner.
- **TURN:**
  - All grants are 0 and a counter runs `TURNAROUND` cycles.
  - On the last TURN cycle, arbitrate over the current `req`. If any request is present, go to OWN; otherwise go to IDLE.
- **Hold counter:**
  - 8-bit; cleared on entry to OWN; increments once per OWN cycle.
  - Saturates; never wraps.
- **Invariants, checked every cycle by the bench:**
  - `$onehot0(grant)`.
  - `drv_en_n == ~grant`.
  - `grant` goes 0 for at least `TURNAROUND` cycles between any two different nonzero values.
  - The same owner is never re-granted without a TURN in between.
- **Reset:**
  - `rst_n` low forces immediately, without waiting for an edge: `grant`=0, `drv_en_n`=all 1s (all drivers Z), `owner`=0, `bus_idle`=1, `preempt`=0, state IDLE, counters 0, `last`=`N_REQ-1`.
  - Reset asserted mid-OWN releases the bus within the same cycle.

## Timing
- Request-to-grant latency from IDLE: `req` sampled high at edge k → `grant` high after edge k+1 (1 cycle).
- Release latency: `req[owner]` sampled low at edge m → `grant` 0 after edge m+1.
- The next owner is granted after edge m+1+`TURNAROUND`.
- `owner` and `bus_idle` update on the same edge as `grant`.
- If `req[owner]` drops on the same edge the hold limit is reached, this is a normal release: `preempt` stays 0.
- If `req` bits glitch during TURN, they are ignored; only the last TURN cycle's sample is used for arbitration.

## Configuration
- Macro `TBA_PREEMPT_EN`.
- **Defined:**
  - When the hold counter reaches `HOLD_MAX` OWN cycles with `req[owner]` still high, the next edge forces TURN.
  - `preempt` pulses high for exactly that one cycle (the first TURN cycle).
  - The preempted agent re-enters round-robin as lowest priority.
- **Not defined:**
  - No preemption; the owner keeps the bus indefinitely.
  - `preempt` is tied 0 and `HOLD_MAX` is unused.

## Test plan
- **Reset:** assert `rst_n`=0 while `grant`=4'b0100 → `grant`=0 and `drv_en_n`=4'b1111 immediately, before the next clock edge. After release with `req`=0 → IDLE, `bus_idle`=1.
- **Single request:** `req`=4'b0010 at edge 1 → `grant`=4'b0010 and `owner`=1 after edge 2. Drop `req` at edge 6 → `grant`=0 after edge 7; `bus_idle`=1.
- **Round-robin:** hold `req`=4'b1111, each owner drops its request after 2 cycles then re-raises it. Grant order is 0,1,2,3,0; every hand-off shows `TURNAROUND`=1 all-Z cycle.
- **Turnaround length:** with `TURNAROUND`=3, owner 0 releases while `req[2]`=1 → exactly 3 cycles with `grant`=0, then `grant`=4'b0100.
- **Preemption** (`TBA_PREEMPT_EN`, `HOLD_MAX`=4): `req`=4'b0011 held constantly. Owner 0 holds for 4 cycles, then `preempt` pulses 1 cycle. After the turnaround, `grant`=4'b0010. Without the macro, `grant`=4'b0001 persists for 100 cycles and `preempt` stays 0.
- **Simultaneous release and arrival:** owner 2 drops `req` on the same edge `req[3]` rises → TURN, then `grant`=4'b1000. `$onehot0(grant)` holds throughout.
